i_cache_axi_rd: RTL and testbench

Memory-side responder for the instruction cache refill port. It accepts the cache's single-word fetch request (`cache_read_ena`/`cache_addr`) and performs one single-beat AXI4 read on the 64-bit bus. It returns the selected 32-bit word with a one-cycle `cache_in_ok` pulse. It sits between `i_cache1` and the AXI4 interconnect/arbiter.

---
 rtl/i_cache_axi_rd_pkg.sv | 9 +
 rtl/i_cache_axi_rd_if.sv | 31 +++
 rtl/i_cache_axi_rd.sv | 105 ++++++++++
 tb/tb_i_cache_axi_rd.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/i_cache_axi_rd_pkg.sv
// Shared AXI4 constants used by the instruction-fetch read responder.
package i_cache_axi_rd_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [2:0] PROT_INSN  = 3'b100;

endpackage

// File: rtl/i_cache_axi_rd_if.sv
// AXI4 read-address and read-data channels between the fetch responder and the interconnect.
interface i_cache_axi_rd_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [2:0]        arprot;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [3:0]        rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, arprot, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, arprot, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/i_cache_axi_rd.sv
// I-cache refill responder: one single-beat AXI4 read per fetch request,
// returning the selected 32-bit half of the 64-bit beat with a one-cycle pulse.
module i_cache_axi_rd
    import i_cache_axi_rd_pkg::*;
#(
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 64,
    parameter logic [3:0] AXI_ID = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cache_read_ena,
    input  logic [63:0]      cache_addr,
    output logic [31:0]      cache_or_data,
    output logic             cache_in_ok,
    output logic             fetch_err,
    output logic [31:0]      fetch_cnt,
    i_cache_axi_rd_if.master axi
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        AR   = 4'b0010,
        R    = 4'b0100,
        RESP = 4'b1000
    } state_t;

    state_t      state_reg;
    logic        hi_word_reg;
    logic        arvalid_reg;
    logic [ADDR_W-1:0] araddr_reg;
    logic [31:0] data_reg;
    logic        ok_reg;
    logic        err_reg;
    logic [31:0] fetch_cnt_reg;

    // Byte offset within the word is irrelevant to a word fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cache_addr[1:0];

    assign axi.arvalid = arvalid_reg;
    assign axi.araddr  = araddr_reg;
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = SIZE_8B;
    assign axi.arburst = BURST_INCR;
    assign axi.arprot  = PROT_INSN;
    assign axi.rready  = (state_reg == R);

    assign cache_or_data = data_reg;
    assign cache_in_ok   = ok_reg;
    assign fetch_err     = err_reg;
    assign fetch_cnt     = fetch_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            hi_word_reg   <= 1'b0;
            arvalid_reg   <= 1'b0;
            araddr_reg    <= '0;
            data_reg      <= '0;
            ok_reg        <= 1'b0;
            err_reg       <= 1'b0;
            fetch_cnt_reg <= '0;
        end else begin
            ok_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cache_read_ena) begin
                        hi_word_reg <= cache_addr[2];
                        araddr_reg  <= ADDR_W'({cache_addr[63:3], 3'b000});
                        arvalid_reg <= 1'b1;
                        state_reg   <= AR;
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= R;
                    end
                end
                R: begin
                    // Output registers load on the beat so they are valid throughout RESP.
                    if (axi.rvalid) begin
                        data_reg  <= hi_word_reg ? axi.rdata[DATA_W-1 -: 32] : axi.rdata[31:0];
                        err_reg   <= (axi.rresp != RESP_OKAY) || !axi.rlast || (axi.rid != AXI_ID);
                        ok_reg    <= 1'b1;
                        if (fetch_cnt_reg != 32'hFFFF_FFFF) begin
                            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
                        end
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    arvalid_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_cache_axi_rd.sv
// Scoreboard bench for i_cache_axi_rd: the bench plays cache and AXI slave.
module tb_i_cache_axi_rd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cache_read_ena = 1'b0;
    logic [63:0] cache_addr = '0;
    logic [31:0] cache_or_data;
    logic        cache_in_ok;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    i_cache_axi_rd_if #(.ADDR_W(64), .DATA_W(64)) axi_if ();

    i_cache_axi_rd #(.ADDR_W(64), .DATA_W(64), .AXI_ID(4'b0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .cache_read_ena (cache_read_ena),
        .cache_addr     (cache_addr),
        .cache_or_data  (cache_or_data),
        .cache_in_ok    (cache_in_ok),
        .fetch_err      (fetch_err),
        .fetch_cnt      (fetch_cnt),
        .axi            (axi_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_cnt = '0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every data-valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (cache_in_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_ok", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("word", {32'd0, cache_or_data}, {32'd0, mon_e.word});
                check_val("err", {63'd0, fetch_err}, {63'd0, mon_e.err});
                $display("fetch done: word=%h err=%0d cnt=%h", cache_or_data, fetch_err, fetch_cnt);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_fetch(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] resp,
                            input logic last, input logic [3:0] id, input int ar_stall, input int r_stall);
        logic [63:0] exp_araddr;
        exp_t        e;
        exp_araddr = {addr[63:3], 3'b000};
        e.word = addr[2] ? data[63:32] : data[31:0];
        e.err  = (resp != 2'b00) || !last || (id != 4'h0);
        exp_q.push_back(e);
        model_cnt = (model_cnt == 32'hFFFF_FFFF) ? model_cnt : model_cnt + 32'd1;

        cache_read_ena = 1'b1;
        cache_addr     = addr;
        @(negedge clk);
        for (int i = 0; i < ar_stall; i++) begin
            check_val("ar_stall_valid", {63'd0, axi_if.arvalid}, 64'd1);
            check_val("ar_stall_addr", axi_if.araddr, exp_araddr);
            cache_addr = {$urandom, $urandom};
            @(negedge clk);
        end
        check_val("arvalid", {63'd0, axi_if.arvalid}, 64'd1);
        check_val("araddr", axi_if.araddr, exp_araddr);
        check_val("arlen", {56'd0, axi_if.arlen}, 64'd0);
        check_val("arsize", {61'd0, axi_if.arsize}, 64'd3);
        check_val("arburst", {62'd0, axi_if.arburst}, 64'd1);
        check_val("arprot", {61'd0, axi_if.arprot}, 64'd4);
        check_val("arid", {60'd0, axi_if.arid}, 64'd0);
        check_val("rready_in_ar", {63'd0, axi_if.rready}, 64'd0);
        axi_if.arready = 1'b1;
        @(negedge clk);
        axi_if.arready = 1'b0;
        for (int i = 0; i < r_stall; i++) begin
            check_val("r_stall_rready", {63'd0, axi_if.rready}, 64'd1);
            check_val("r_stall_ok", {63'd0, cache_in_ok}, 64'd0);
            @(negedge clk);
        end
        check_val("rready", {63'd0, axi_if.rready}, 64'd1);
        check_val("arvalid_dropped", {63'd0, axi_if.arvalid}, 64'd0);
        axi_if.rvalid = 1'b1;
        axi_if.rdata  = data;
        axi_if.rresp  = resp;
        axi_if.rlast  = last;
        axi_if.rid    = id;
        @(negedge clk);
        axi_if.rvalid = 1'b0;
        axi_if.rdata  = {$urandom, $urandom};
        check_val("ok_latency", {63'd0, cache_in_ok}, 64'd1);
        check_val("rready_in_resp", {63'd0, axi_if.rready}, 64'd0);
        // Request stays high through RESP; it must not start a new read there.
        @(negedge clk);
        cache_read_ena = 1'b0;
        check_val("ok_pulse", {63'd0, cache_in_ok}, 64'd0);
        check_val("no_relatch", {63'd0, axi_if.arvalid}, 64'd0);
        check_val("cnt", {32'd0, fetch_cnt}, {32'd0, model_cnt});
        check_val("data_hold", {32'd0, cache_or_data}, {32'd0, e.word});
    endtask

    initial begin
        axi_if.arready = 1'b0;
        axi_if.rvalid  = 1'b0;
        axi_if.rdata   = '0;
        axi_if.rresp   = 2'b00;
        axi_if.rlast   = 1'b0;
        axi_if.rid     = 4'h0;

        repeat (3) @(negedge clk);
        check_val("rst_arvalid", {63'd0, axi_if.arvalid}, 64'd0);
        check_val("rst_rready", {63'd0, axi_if.rready}, 64'd0);
        check_val("rst_ok", {63'd0, cache_in_ok}, 64'd0);
        check_val("rst_data", {32'd0, cache_or_data}, 64'd0);
        check_val("rst_err", {63'd0, fetch_err}, 64'd0);
        check_val("rst_cnt", {32'd0, fetch_cnt}, 64'd0);
        check_val("rst_araddr", axi_if.araddr, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_fetch(64'h8000_0004, 64'h0010_0093_0000_0013, 2'b00, 1'b1, 4'h0, 0, 0);
        do_fetch(64'h8000_0010, 64'h0010_0093_0000_0013, 2'b00, 1'b1, 4'h0, 0, 0);
        do_fetch(64'h8000_0026, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 1'b1, 4'h0, 5, 0);
        do_fetch(64'h1234_5679, 64'h0BAD_F00D_1357_9BDF, 2'b00, 1'b1, 4'h0, 0, 3);
        do_fetch(64'h8000_0044, 64'hAAAA_5555_1111_2222, 2'b10, 1'b1, 4'h0, 1, 1);
        do_fetch(64'h8000_0048, 64'h3333_4444_5555_6666, 2'b00, 1'b0, 4'h0, 0, 0);
        do_fetch(64'h8000_004C, 64'h7777_8888_9999_AAAA, 2'b00, 1'b1, 4'h3, 0, 0);

        // Reset while waiting in R with no beat offered.
        cache_read_ena = 1'b1;
        cache_addr     = 64'h8000_0100;
        @(negedge clk);
        axi_if.arready = 1'b1;
        @(negedge clk);
        axi_if.arready = 1'b0;
        cache_read_ena = 1'b0;
        check_val("mid_r_rready", {63'd0, axi_if.rready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check_val("midr_arvalid", {63'd0, axi_if.arvalid}, 64'd0);
        check_val("midr_rready", {63'd0, axi_if.rready}, 64'd0);
        check_val("midr_ok", {63'd0, cache_in_ok}, 64'd0);
        check_val("midr_data", {32'd0, cache_or_data}, 64'd0);
        check_val("midr_err", {63'd0, fetch_err}, 64'd0);
        check_val("midr_cnt", {32'd0, fetch_cnt}, 64'd0);
        check_val("midr_araddr", axi_if.araddr, 64'd0);
        model_cnt = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("midr_quiet", {63'd0, cache_in_ok}, 64'd0);
        do_fetch(64'h8000_0104, 64'hFEED_FACE_0123_4567, 2'b00, 1'b1, 4'h0, 0, 0);

        // Counter saturation.
        force dut.fetch_cnt_reg = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.fetch_cnt_reg;
        model_cnt = 32'hFFFF_FFFE;
        check_val("cnt_preset", {32'd0, fetch_cnt}, {32'd0, model_cnt});
        for (int k = 0; k < 3; k++) begin
            do_fetch({32'h8000_0000, $urandom}, {$urandom, $urandom}, 2'b00, 1'b1, 4'h0, k, 0);
        end

        repeat (2) @(negedge clk);
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
